// File: rtl/occupancy_pkg.sv
// Shared types and helpers for the log-odds occupancy grid.
//   occ_state_t : control FSM states (CLEAR sweep, RUN, DRAIN before a clear)
//   cell_t      : signed log-odds word at the default 8-bit width
//   x_idx_t/y_idx_t : cell indices at the default 64x64 grid size
//   idx_w/addr_w: index and linear-address widths (never below 1 bit)
//   clamp       : saturate an integer into [lo, hi]
package occupancy_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } occ_state_t;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_WIDTH  = 64;
  localparam int DEF_HEIGHT = 64;

  typedef logic signed [DEF_WORD_W-1:0]       cell_t;
  typedef logic [$clog2(DEF_WIDTH)-1:0]       x_idx_t;
  typedef logic [$clog2(DEF_HEIGHT)-1:0]      y_idx_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w(input int w, input int h);
    return idx_w(w * h);
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/occupancy_lo_ram.sv
// Simple dual-port cell RAM: one write port, one read port, 1-cycle
// registered read. A read and write to the same address in one cycle
// returns the old contents.
//   clock        : system clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, rdata valid the cycle after raddr
module occupancy_lo_ram #(
  parameter int DEPTH = 4096,
  parameter int W     = 8,
  parameter int AW    = 12
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/occupancy_logodds_ctrl.sv
// Control unit: CLEAR/RUN FSM and clear-address counter.
//   clock, reset : system clock, synchronous active-high reset
//   zero_memory  : request a full clear (restarts a running sweep)
//   run          : grid accepts updates/queries
//   clr_we       : clear write strobe, clr_addr is the address being cleared
// Leaving RUN goes through one DRAIN cycle so the update already in its
// write stage lands before the sweep takes over the write port.
module occupancy_logodds_ctrl
  import occupancy_pkg::*;
#(
  parameter int N  = 4096,
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          zero_memory,
  output logic          run,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  occ_state_t    state, nxt;
  logic [AW-1:0] cnt;
  logic          last;

  assign last     = (cnt == AW'(N - 1));
  assign clr_addr = cnt;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_CLEAR;
    else       state <= nxt;
  end

  always_ff @(posedge clock) begin
    if (reset)                                     cnt <= '0;
    else if (state != ST_CLEAR || zero_memory || last) cnt <= '0;
    else                                           cnt <= cnt + AW'(1);
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_CLEAR: if (!zero_memory && last) nxt = ST_RUN;
      ST_RUN:   if (zero_memory)          nxt = ST_DRAIN;
      ST_DRAIN:                           nxt = ST_CLEAR;
      default:                            nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    run    = (state == ST_RUN);
    clr_we = (state == ST_CLEAR);
  end

endmodule

// File: rtl/occupancy_logodds.sv
// Log-odds occupancy grid. Holds WIDTH x HEIGHT signed words and applies
// saturating hit/miss updates through a 2-stage read-modify-write pipeline
// (one update per cycle, same-cell hazards resolved by forwarding the
// previous cycle's write). A query port reads cells for the matcher.
//   clock, reset       : system clock, synchronous active-high reset
//   zero_memory        : pulse, request a full-grid clear
//   upd_valid/ready, upd_x, upd_y, upd_free : update request (free = miss)
//   q_valid/ready, q_x, q_y                 : query request
//   q_data_valid, q_data, q_occupied        : query result, 1 cycle later
//   busy    : clear in progress or update pipeline not empty
//   err_oob : sticky, an out-of-range update was dropped
module occupancy_logodds
  import occupancy_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int WORD_W     = 8,
  parameter int HIT_INC    = 3,
  parameter int MISS_DEC   = 1,
  parameter int LO_MAX     = 127,
  parameter int LO_MIN     = -128,
  parameter int INIT_VAL   = 0,
  parameter int OCC_THRESH = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       zero_memory,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [$clog2(WIDTH)-1:0]   upd_x,
  input  logic [$clog2(HEIGHT)-1:0]  upd_y,
  input  logic                       upd_free,
  input  logic                       q_valid,
  output logic                       q_ready,
  input  logic [$clog2(WIDTH)-1:0]   q_x,
  input  logic [$clog2(HEIGHT)-1:0]  q_y,
  output logic                       q_data_valid,
  output logic [WORD_W-1:0]          q_data,
  output logic                       q_occupied,
  output logic                       busy,
  output logic                       err_oob
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int AW = addr_w(WIDTH, HEIGHT);

  typedef logic signed [WORD_W-1:0] word_t;
  typedef logic signed [WORD_W+1:0] wide_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          oob;
    logic          free;
  } upd_req_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          oob;
  } q_req_t;

  // control
  logic          run, clr_we;
  logic [AW-1:0] clr_addr;

  occupancy_logodds_ctrl #(.N(N), .AW(AW)) u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .zero_memory (zero_memory),
    .run         (run),
    .clr_we      (clr_we),
    .clr_addr    (clr_addr)
  );

  // request decode; out-of-range requests map to address 0 so the RAM is
  // never indexed past its depth
  logic          upd_acc, q_acc, upd_oob, q_oob;
  logic [AW-1:0] upd_lin, q_lin;

  assign upd_ready = run;
  assign q_ready   = run && !upd_valid;
  assign upd_acc   = upd_valid && run;
  assign q_acc     = q_valid && q_ready;

  assign upd_oob = (32'(upd_x) >= WIDTH) || (32'(upd_y) >= HEIGHT);
  assign q_oob   = (32'(q_x) >= WIDTH) || (32'(q_y) >= HEIGHT);
  assign upd_lin = upd_oob ? '0 : AW'(upd_y) * AW'(WIDTH) + AW'(upd_x);
  assign q_lin   = q_oob ? '0 : AW'(q_y) * AW'(WIDTH) + AW'(q_x);

  // pipeline registers: S1 update, query response, last write
  upd_req_t s1;
  q_req_t   qr;
  logic     s1_vld, qr_vld, lw_vld;
  logic [AW-1:0] lw_addr;
  word_t    lw_data;

  // S1 datapath
  word_t s1_old, s1_new, rd_data, q_word;
  wide_t s1_sum;
  logic  s1_we;

  // S0: updates and queries never share a cycle, so one read port serves both
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  word_t         ram_wdata;

  assign ram_raddr = upd_acc ? upd_lin : q_lin;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld <= 1'b0;
      qr_vld <= 1'b0;
      lw_vld <= 1'b0;
      err_oob <= 1'b0;
    end else begin
      s1_vld <= upd_acc;
      qr_vld <= q_acc;
      lw_vld <= s1_we;
      if (upd_acc && upd_oob) err_oob <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (upd_acc) s1 <= '{addr: upd_lin, oob: upd_oob, free: upd_free};
    if (q_acc)   qr <= '{addr: q_lin, oob: q_oob};
    if (s1_we) begin
      lw_addr <= s1.addr;
      lw_data <= s1_new;
    end
  end

  // RAM has the previous cycle's write too late for a read issued in that
  // same cycle; the last-write register covers exactly that one-cycle gap.
  always_comb begin
    s1_old = (lw_vld && lw_addr == s1.addr) ? lw_data : rd_data;
    s1_sum = wide_t'(s1_old) + (s1.free ? -wide_t'(MISS_DEC) : wide_t'(HIT_INC));
    s1_new = word_t'(clamp(int'(s1_sum), LO_MIN, LO_MAX));
    s1_we  = s1_vld && !s1.oob;
  end

  // clear and S1 never overlap: the FSM drains S1 before sweeping
  always_comb begin
    ram_we    = clr_we || s1_we;
    ram_waddr = clr_we ? clr_addr : s1.addr;
    ram_wdata = clr_we ? word_t'(INIT_VAL) : s1_new;
  end

  occupancy_lo_ram #(.DEPTH(N), .W(WORD_W), .AW(AW)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (rd_data)
  );

  // query response
  always_comb begin
    if (qr.oob)                            q_word = word_t'(INIT_VAL);
    else if (lw_vld && lw_addr == qr.addr) q_word = lw_data;
    else                                   q_word = rd_data;
  end

  assign q_data_valid = qr_vld;
  assign q_data       = qr_vld ? q_word : '0;
  assign q_occupied   = qr_vld && (int'(q_word) > OCC_THRESH);

  // DRAIN counts as part of the clear so busy has no gap before the sweep
  assign busy = !run || upd_acc || s1_vld;

endmodule
